// File: rtl/fake_n64_pkg.sv
// Shared command codes, reply lengths and host FSM states for the fake N64 link.
package fake_n64_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [5:0] RESP_LEN_STATUS = 6'd24;
  localparam logic [5:0] RESP_LEN_POLL   = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_SAMPLE,
    RX_STOP
  } host_state_e;

  // Reply length the controller is expected to send back for a command.
  function automatic logic [5:0] expected_len(input logic [7:0] cmd);
    case (cmd)
      CMD_STATUS, CMD_RESET: return RESP_LEN_STATUS;
      CMD_POLL:              return RESP_LEN_POLL;
      default:               return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/fake_n64_line_sync.sv
// Two-flop synchroniser for the open-drain N64 data line, with fall/rise pulses.
module fake_n64_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta, sync, prev;

  // Idle line is high, so all stages come out of reset at 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;
  assign rise  = ~prev & sync;

endmodule

// File: rtl/fake_n64_console_host.sv
// Console-side N64 link master: serialises a command byte, then decodes the reply.
// Optional auto-poll (cmd 0x01 every POLL_PERIOD_CLKS) under `FAKE_N64_HOST_AUTO_POLL_EN.
module fake_n64_console_host
  import fake_n64_pkg::*;
#(
  parameter int US_CLKS          = 4,
  parameter int TIMEOUT_CLKS     = 32,
  parameter int POLL_PERIOD_CLKS = 64000
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd_in,
  input  logic        data_rx,
  output logic        data_tx,
  output logic        busy,
  output logic [31:0] resp_data,
  output logic [5:0]  resp_len,
  output logic        resp_valid,
  output logic        timeout
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] QTR_LAST     = CNT_W'(US_CLKS - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(4 * US_CLKS - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(2 * US_CLKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] ONE_HIGH_AT  = CNT_W'(US_CLKS);
  localparam logic [CNT_W-1:0] ZERO_HIGH_AT = CNT_W'(3 * US_CLKS);

  if (US_CLKS < 2 || TIMEOUT_CLKS < 1 || POLL_PERIOD_CLKS < 2) begin : g_bad_params
    $error("fake_n64_console_host: parameter out of range");
  end

  host_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [5:0]       left_q, left_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [5:0]       len_q, len_d;
  logic             stop_q, stop_d;
  logic [31:0]      resp_data_d;
  logic [5:0]       resp_len_d;
  logic             resp_valid_d, timeout_d;
  logic             rx_level, rx_fall, rx_rise;
  logic             req, accept;
  logic [7:0]       req_cmd;

  fake_n64_line_sync u_rx_sync (
    .clk   (sample_clk),
    .reset (reset),
    .din   (data_rx),
    .level (rx_level),
    .fall  (rx_fall),
    .rise  (rx_rise)
  );

  // A start coinciding with the completion pulse is dropped, not queued.
  assign accept = (state_q == IDLE) && req && !resp_valid && !timeout;
  assign busy   = (state_q != IDLE);

`ifdef FAKE_N64_HOST_AUTO_POLL_EN
  localparam int PW = $clog2(POLL_PERIOD_CLKS) + 1;
  logic [PW-1:0] poll_cnt_q;
  logic          poll_pend_q;
  logic          poll_tick;

  assign poll_tick = (poll_cnt_q == PW'(POLL_PERIOD_CLKS - 1));
  assign req       = start | poll_pend_q;
  assign req_cmd   = start ? cmd_in : CMD_POLL;

  // Poll request stays pending across a busy period; external start wins a tie.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
    end else begin
      poll_cnt_q <= poll_tick ? '0 : poll_cnt_q + PW'(1);
      if (poll_tick)
        poll_pend_q <= 1'b1;
      else if (accept && !start)
        poll_pend_q <= 1'b0;
    end
  end
`else
  assign req     = start;
  assign req_cmd = cmd_in;
`endif

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      resp_data  <= '0;
      resp_len   <= '0;
      resp_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      resp_data  <= resp_data_d;
      resp_len   <= resp_len_d;
      resp_valid <= resp_valid_d;
      timeout    <= timeout_d;
    end
  end

  always_ff @(posedge sample_clk) begin
    bit_q  <= bit_d;
    left_q <= left_d;
    cmd_q  <= cmd_d;
    len_q  <= len_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    left_d       = left_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    stop_d       = stop_q;
    resp_data_d  = resp_data;
    resp_len_d   = resp_len;
    resp_valid_d = 1'b0;
    timeout_d    = 1'b0;
    data_tx      = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d       = req_cmd;
          len_d       = expected_len(req_cmd);
          resp_data_d = '0;
          resp_len_d  = '0;
          cnt_d       = '0;
          bit_d       = 3'd7;
          state_d     = TX_BIT;
        end
      end
      TX_BIT: begin
        data_tx = cmd_q[bit_q] ? (cnt_q >= ONE_HIGH_AT) : (cnt_q >= ZERO_HIGH_AT);
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd0) state_d = TX_STOP;
          else               bit_d   = bit_q - 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        data_tx = 1'b0;
        if (cnt_q == QTR_LAST) begin
          cnt_d = '0;
          if (len_q == 6'd0) begin
            resp_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            left_d  = len_q;
            state_d = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT: begin
        if (rx_fall) begin
          cnt_d   = '0;
          state_d = RX_SAMPLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          resp_data_d = {resp_data[30:0], rx_level};
          left_d      = left_q - 6'd1;
          cnt_d       = '0;
          stop_d      = 1'b0;
          state_d     = (left_q == 6'd1) ? RX_STOP : RX_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // The last data bit's own rising edge lands here too; only a rise after the stop fall counts.
        if (stop_q && rx_rise) begin
          resp_valid_d = 1'b1;
          resp_len_d   = len_q;
          state_d      = IDLE;
        end else if (!stop_q && rx_fall) begin
          stop_d = 1'b1;
          cnt_d  = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/fake_n64_console_host.md
Name: fake_n64_console_host

Overview:
- Console-side master for the fake N64 controller link: drives the command line into the controller's data_rx and decodes the reply arriving on the controller's data_tx.
- Serialises one 8-bit command with N64 quarter-bit encoding, turns around, samples the reply bits, then presents a parallel response word with a valid pulse.
- Sits directly upstream and downstream of the controller. Used as the bench and board-level driver for the controller pair.

Parameters:
- US_CLKS, 4, sample_clk cycles per 1 us quarter-bit (min 2).
- TIMEOUT_CLKS, 32, idle cycles allowed while waiting for a reply falling edge.
- POLL_PERIOD_CLKS, 64000, auto-poll interval in cycles (used only with the optional feature).

Ports:
- sample_clk, input, 1: the only clock.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle request to send cmd_in. Ignored while busy.
- cmd_in, input, 8: command byte, captured on the start cycle.
- data_rx, input, 1: reply line from the controller's data_tx. Asynchronous; 1 = high.
- data_tx, output, 1: command line to the controller's data_rx. 1 = released/high.
- busy, output, 1: transaction in progress.
- resp_data, output, 32: reply bits, right-aligned, first bit received in the MSB of the valid field.
- resp_len, output, 6: number of reply bits in resp_data (0, 24 or 32).
- resp_valid, output, 1: one-cycle pulse; resp_data and resp_len are stable from this pulse until the next start.
- timeout, output, 1: one-cycle pulse when the reply is missing or truncated.

Behaviour:
- Clock and reset: one clock (sample_clk); reset is synchronous and active-high.
- Reset values: data_tx=1, busy=0, resp_valid=0, timeout=0, resp_data=0, resp_len=0, FSM=IDLE.
- Reset asserted mid-transaction: line released and FSM in IDLE at the next edge. No pulse is emitted.
- data_rx path: 2-flop synchroniser, then an edge detector. Decode timing below is measured from the synchronised edge.
- Expected reply length from the latched command: 0x00 -> 24, 0xFF -> 24, 0x01 -> 32, any other value -> 0.
- IDLE: a start pulse latches cmd_in and sets busy=1. data_tx goes low on the next cycle (latency 1) and the FSM enters TX_BIT.
- TX_BIT: sends 8 bits MSB first, 4*US_CLKS cycles per bit.
  - Bit 0: low for 3 quarters, high for 1.
  - Bit 1: low for 1 quarter, high for 3.
- TX_STOP: low for 1 quarter, then release.
  - Expected length 0: resp_valid with resp_len=0, then IDLE.
  - Otherwise: enter RX_WAIT.
- RX_WAIT: counts cycles.
  - A synchronised falling edge goes to RX_SAMPLE and clears the counter.
  - The counter reaching TIMEOUT_CLKS pulses timeout and goes to IDLE with busy=0. resp_data keeps its old value.
- RX_SAMPLE: exactly 2*US_CLKS cycles after the falling edge, shift the synchronised level into the LSB of resp_data.
  - More bits expected: return to RX_WAIT.
  - Last bit: go to RX_STOP.
- RX_STOP: waits for the controller stop bit (falling edge), with the same timeout rule as RX_WAIT.
  - On the stop bit's rising edge: resp_valid=1, resp_len set, busy=0 in the same cycle, then IDLE.
  - Timeout here: pulse timeout only; no resp_valid.
- resp_data is cleared to 0 when a transaction starts, so unused upper bits read 0 for 24-bit replies.
- resp_valid and timeout never assert in the same cycle.
- start arriving in the same cycle as resp_valid or timeout is ignored; it is accepted from the following cycle.
- Reply edges arriving during TX states are ignored; the line is owned by the host.

Optional Feature:
- Macro: FAKE_N64_HOST_AUTO_POLL_EN.
- Defined: a free-running counter issues an internal start with cmd 0x01 every POLL_PERIOD_CLKS cycles when idle.
  - If busy at the tick, the request is held pending until IDLE.
  - External start has priority in the same cycle.
- Undefined: no counter. Transactions occur only on external start.

Decomposition:
- Package fake_n64_pkg holds:
  - CMD_STATUS=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF.
  - RESP_LEN_STATUS=24, RESP_LEN_POLL=32.
  - FSM state enum: IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_SAMPLE, RX_STOP.
- Sub-module fake_n64_line_sync: 2-flop synchroniser plus fall/rise edge pulses. Reusable by the controller's rx side.

Test Plan (US_CLKS=4):
- start, cmd 0x01 -> data_tx shows 7 bits of 12 low/4 high, then 1 bit of 4 low/12 high, then 4 low stop, all starting 1 cycle after start. Controller model replies 32'hA5C3_0F01 -> resp_valid with resp_data=32'hA5C3_0F01, resp_len=32.
- start, cmd 0x00 with a 24-bit reply 24'h050002 -> resp_data=32'h0005_0002, resp_len=24, upper byte 0.
- start, cmd 0x01 with data_rx held high -> timeout pulse exactly 32 cycles after RX_WAIT entry; busy drops; no resp_valid.
- Reply truncated after 10 bits -> timeout pulse; resp_valid never asserts.
- reset asserted mid-TX_BIT -> data_tx=1 and busy=0 next edge. A fresh start then completes normally.
- Feature on, POLL_PERIOD_CLKS=200, with an external start overlapping the poll tick -> the external cmd goes first, the poll is issued immediately after it completes, and a 0x01 poll then follows every 200 cycles.
